// File: rtl/spi_sck_engine.sv
// spi_sck_engine: SPI serial-clock engine with two runtime rates, programmable
// idle polarity, exact bit count per burst, and SCK-aligned launch/sample/done
// strobes. Optional build macro SPI_CPHA_EN adds the cpha input (mode 1/3
// strobe placement); without it the engine is fixed to mode 0/2 strobes.
module spi_sck_engine #(
    parameter int CLK_DIV_NORM = 40,
    parameter int CLK_DIV_FAST = 4,
    parameter int LEN_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fast,
    input  logic             cpol,
    input  logic [LEN_W-1:0] nbits,
`ifdef SPI_CPHA_EN
    input  logic             cpha,
`endif
    output logic             busy,
    output logic             sck,
    output logic             launch_stb,
    output logic             sample_stb,
    output logic             done
);

    localparam int H_NORM = CLK_DIV_NORM / 2;
    localparam int H_FAST = CLK_DIV_FAST / 2;
    localparam int H_MAX  = (H_NORM > H_FAST) ? H_NORM : H_FAST;
    localparam int CW     = (H_MAX > 1) ? $clog2(H_MAX) : 1;

    localparam logic [CW-1:0] HN_LAST = CW'(H_NORM - 1);
    localparam logic [CW-1:0] HF_LAST = CW'(H_FAST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LEN_W:0]    edge_q, edge_d;
    logic              fast_q, fast_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [LEN_W-1:0]  nbits_q, nbits_d;
    logic              busy_q, busy_d;
    logic              sck_q, sck_d;
    logic              launch_q, launch_d;
    logic              sample_q, sample_d;
    logic              done_q, done_d;

    logic              cpha_in;
    logic [CW-1:0]     half_last;
    logic [LEN_W:0]    edge_inc;
    logic [LEN_W:0]    edge_final;
    logic              half_wrap;

`ifdef SPI_CPHA_EN
    assign cpha_in = cpha;
`else
    assign cpha_in = 1'b0;
`endif

    // Half-period terminal count follows the rate latched at start.
    assign half_last  = fast_q ? HF_LAST : HN_LAST;
    assign half_wrap  = (cnt_q == half_last);
    assign edge_inc   = edge_q + (LEN_W+1)'(1);
    assign edge_final = {nbits_q, 1'b0};

    // State and output registers; every output is a flop so strobes line up with sck.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            fast_q   <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            nbits_q  <= '0;
            busy_q   <= 1'b0;
            sck_q    <= 1'b0;
            launch_q <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            fast_q   <= fast_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            nbits_q  <= nbits_d;
            busy_q   <= busy_d;
            sck_q    <= sck_d;
            launch_q <= launch_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: half-period counting, edge sequencing and strobe generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        fast_d   = fast_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        nbits_d  = nbits_q;
        busy_d   = busy_q;
        sck_d    = sck_q;
        launch_d = 1'b0;
        sample_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                sck_d  = cpol;
                cnt_d  = '0;
                edge_d = '0;
                // The done cycle still counts as busy for request purposes.
                if (start && !done_q) begin
                    if (nbits != '0) begin
                        fast_d   = fast;
                        cpol_d   = cpol;
                        cpha_d   = cpha_in;
                        nbits_d  = nbits;
                        busy_d   = 1'b1;
                        launch_d = !cpha_in;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (half_wrap) begin
                    cnt_d  = '0;
                    sck_d  = !sck_q;
                    edge_d = edge_inc;
                    if (edge_inc[0]) begin
                        // Odd edge numbers are leading edges.
                        if (cpha_q) launch_d = 1'b1;
                        else        sample_d = 1'b1;
                    end else begin
                        if (cpha_q)                       sample_d = 1'b1;
                        else if (edge_inc != edge_final)  launch_d = 1'b1;
                        if (edge_inc == edge_final)       state_d  = TAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            TAIL: begin
                sck_d = cpol_q;
                if (half_wrap) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
                edge_d  = '0;
            end
        endcase
    end

    assign busy       = busy_q;
    assign sck        = sck_q;
    assign launch_stb = launch_q;
    assign sample_stb = sample_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spi_sck_engine.sv
// Bench for spi_sck_engine: a per-cycle timing model derived from the burst
// timing rules, plus literal checks on the documented scenarios.
module tb_spi_sck_engine;

    localparam int DIVN  = 40;
    localparam int DIVF  = 4;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic fast = 1'b0;
    logic cpol = 1'b0;
    logic [LEN_W-1:0] nbits = '0;
    logic cpha = 1'b0;
    logic busy, sck, launch_stb, sample_stb, done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;

    spi_sck_engine #(.CLK_DIV_NORM(DIVN), .CLK_DIV_FAST(DIVF), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .fast(fast), .cpol(cpol), .nbits(nbits),
`ifdef SPI_CPHA_EN
        .cpha(cpha),
`endif
        .busy(busy), .sck(sck), .launch_stb(launch_stb), .sample_stb(sample_stb), .done(done)
    );

    always #5 clk = !clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: one accepted burst described by its start cycle and settings.
    bit m_active = 0;
    int m_T, m_N, m_H;
    bit m_cpol, m_cpha;
    int m_zero_done = -1;
    bit m_rst_prev = 1;
    bit m_cpol_prev = 0;

    // Per-test statistics, cycles relative to t0.
    int first_rise, first_fall, last_fall, done_rel, first_launch, first_sample, first_busy;
    int rises, falls, launches, samples, dones, snap101;
    bit sck_prev = 0;

    task automatic clear_stats();
        t0 = cyc;
        first_rise = -1; first_fall = -1; last_fall = -1; done_rel = -1;
        first_launch = -1; first_sample = -1; first_busy = -1;
        rises = 0; falls = 0; launches = 0; samples = 0; dones = 0; snap101 = -1;
    endtask

    // Compare process: expected outputs from the burst timing formulas.
    always @(negedge clk) begin
        int r, e, endr, rel;
        bit eb, es, el, esm, ed;
        eb = 0; es = m_cpol_prev; el = 0; esm = 0; ed = 0;
        if (m_rst_prev) begin
            es = 0;
        end else begin
            if (m_active) begin
                r = cyc - m_T - 1;
                endr = (2 * m_N + 1) * m_H;
                if (r == endr) begin
                    ed = 1; es = m_cpol;
                end else if (r >= 0 && r < endr) begin
                    eb = 1;
                    e = r / m_H;
                    if (e > 2 * m_N) e = 2 * m_N;
                    es = m_cpol ^ e[0];
                    if (r == 0 && !m_cpha) el = 1;
                    if (r % m_H == 0 && e >= 1 && e <= 2 * m_N) begin
                        if (e % 2 == 1) begin
                            if (m_cpha) el = 1; else esm = 1;
                        end else begin
                            if (m_cpha) esm = 1;
                            else if (e < 2 * m_N) el = 1;
                        end
                    end
                end
            end
            if (m_zero_done == cyc) ed = 1;
        end

        if (cyc >= 1) begin
            vectors++;
            if ({busy, sck, launch_stb, sample_stb, done} !== {eb, es, el, esm, ed}) begin
                miscompares++;
                $display("FAIL cycle_model cyc=%0d got busy/sck/launch/sample/done=%b%b%b%b%b required %b%b%b%b%b",
                         cyc, busy, sck, launch_stb, sample_stb, done, eb, es, el, esm, ed);
            end
        end

        rel = cyc - t0;
        if (sck === 1'b1 && !sck_prev) begin rises++; if (first_rise < 0) first_rise = rel; end
        if (sck === 1'b0 && sck_prev) begin falls++; last_fall = rel; if (first_fall < 0) first_fall = rel; end
        if (launch_stb === 1'b1) begin launches++; if (first_launch < 0) first_launch = rel; end
        if (sample_stb === 1'b1) begin samples++; if (first_sample < 0) first_sample = rel; end
        if (done === 1'b1) begin dones++; done_rel = rel; end
        if (busy === 1'b1 && first_busy < 0) first_busy = rel;
        if (rel == 101) snap101 = int'({busy, sck, launch_stb, sample_stb, done});
        sck_prev = (sck === 1'b1);

        // Advance the model with this cycle's inputs.
        if (m_active && (cyc - m_T - 1) >= (2 * m_N + 1) * m_H) m_active = 0;
        if (reset) begin
            m_active = 0;
            m_zero_done = -1;
        end else if (start && !eb && !ed) begin
            if (nbits != 0) begin
                m_active = 1; m_T = cyc; m_N = int'(nbits);
                m_H = fast ? DIVF / 2 : DIVN / 2;
                m_cpol = cpol;
`ifdef SPI_CPHA_EN
                m_cpha = cpha;
`else
                m_cpha = 0;
`endif
            end else begin
                m_zero_done = cyc + 1;
            end
        end
        m_rst_prev = reset;
        m_cpol_prev = cpol;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic until_rel(input int rel);
        while (cyc - t0 < rel) step(1);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    // Pulse start for one cycle with the given settings; stats restart at this cycle.
    task automatic kick(input bit f, input bit p, input int n);
        fast = f; cpol = p; nbits = LEN_W'(n);
        clear_stats();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        clear_stats();
        step(3);
        chk("reset_outputs", int'({busy, sck, launch_stb, sample_stb, done}), 0);
        reset = 1'b0;
        step(3);

        // Normal mode, cpol=0, 8 bits.
        kick(0, 0, 8);
        until_rel(360);
        $display("burst norm n=8: rise1=%0d rises=%0d lastfall=%0d done=%0d", first_rise, rises, last_fall, done_rel);
        chk("n8_busy_rise", first_busy, 1);
        chk("n8_first_rise", first_rise, 21);
        chk("n8_rises", rises, 8);
        chk("n8_last_fall", last_fall, 321);
        chk("n8_done", done_rel, 341);
        chk("n8_samples", samples, 8);
        chk("n8_launches", launches, 8);
        chk("n8_first_launch", first_launch, 1);

        // Fast mode, 3 bits, with a start attempt in the done cycle.
        kick(1, 0, 3);
        until_rel(15);
        start = 1'b1; step(1); start = 1'b0;
        until_rel(40);
        $display("burst fast n=3: rise1=%0d done=%0d dones=%0d", first_rise, done_rel, dones);
        chk("fast_first_rise", first_rise, 3);
        chk("fast_rises", rises, 3);
        chk("fast_done", done_rel, 15);
        chk("fast_done_count", dones, 1);

        // cpol=1, 2 bits.
        cpol = 1'b1; step(3);
        kick(0, 1, 2);
        until_rel(120);
        $display("burst cpol1 n=2: fall1=%0d done=%0d", first_fall, done_rel);
        chk("cpol1_first_fall", first_fall, 21);
        chk("cpol1_falls", falls, 2);
        chk("cpol1_done", done_rel, 101);
        cpol = 1'b0; step(3);

        // Second start while busy; mid-burst input changes.
        kick(0, 0, 4);
        until_rel(10); fast = 1'b1; nbits = 16'd9;
        until_rel(50); start = 1'b1; step(1); start = 1'b0;
        until_rel(150); fast = 1'b0; nbits = 16'd4;
        until_rel(400);
        $display("burst n=4 restart: done=%0d dones=%0d rises=%0d", done_rel, dones, rises);
        chk("dup_done", done_rel, 181);
        chk("dup_done_count", dones, 1);
        chk("dup_rises", rises, 4);

        // Reset in the middle of an 8-bit burst.
        kick(0, 0, 8);
        until_rel(100); reset = 1'b1; step(1); reset = 1'b0;
        until_rel(400);
        $display("burst reset at 100: snap101=%0d dones=%0d", snap101, dones);
        chk("rst_snap101", snap101, 0);
        chk("rst_no_done", dones, 0);

        // Zero-length request.
        kick(0, 0, 0);
        until_rel(30);
        $display("burst n=0: done=%0d busy1=%0d rises=%0d", done_rel, first_busy, rises);
        chk("zero_done", done_rel, 1);
        chk("zero_busy", first_busy, -1);
        chk("zero_rises", rises, 0);

`ifdef SPI_CPHA_EN
        cpha = 1'b1;
        kick(0, 0, 8);
        cpha = 1'b0;
        until_rel(360);
        $display("burst cpha n=8: launch1=%0d sample1=%0d done=%0d", first_launch, first_sample, done_rel);
        chk("cpha_first_launch", first_launch, 21);
        chk("cpha_first_sample", first_sample, 41);
        chk("cpha_launches", launches, 8);
        chk("cpha_samples", samples, 8);
        chk("cpha_done", done_rel, 341);
`endif

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
